hsv_object_tracker: RTL

- Per-object consumer of the threshold set produced by the HSV threshold-adjust stage (one instance each for puck, paddle1 and paddle2).
- Classifies each streamed HSV pixel against that object's h1/h2/s/v min/max window and emits a registered mask bit for the display overlay.
- Accumulates sum-x, sum-y and pixel count over each frame. At frame end, a sequential divider computes the object centroid for the game logic.

---
 rtl/airpong_pkg.sv | 28 ++
 rtl/hsv_object_tracker_div.sv | 57 +++++
 rtl/hsv_object_tracker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/airpong_pkg.sv
// Shared AirPong types and constants: object/HSV select
// encodings, screen geometry and the tracker FSM states.
package airpong_pkg;

  typedef enum logic [1:0] {
    PUCK    = 2'd0,
    PADDLE1 = 2'd1,
    PADDLE2 = 2'd2
  } obj_sel_e;

  typedef enum logic [1:0] {
    H = 2'd0,
    S = 2'd1,
    V = 2'd2
  } hsv_sel_e;

  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int MIN_PIXELS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_X = 2'd1,
    DIV_Y = 2'd2,
    DONE  = 2'd3
  } trk_state_e;

endpackage

// File: rtl/hsv_object_tracker_div.sv
// seq_divider: restoring unsigned divider, one quotient bit per
// cycle. Ports: start loads operands, done flags the last step
// while quotient carries the finished result combinationally.
module seq_divider #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  dvd;
  logic [W-1:0]  dsr;
  logic [W:0]    rem;
  logic [CW-1:0] cnt;
  logic          run;

  logic [W:0]    sh;
  logic          ge;
  logic [W:0]    rem_n;

  always_comb begin
    sh       = {rem[W-1:0], dvd[W-1]};
    ge       = sh >= {1'b0, dsr};
    rem_n    = ge ? sh - {1'b0, dsr} : sh;
    quotient = {dvd[W-2:0], ge};
    done     = run && (cnt == CW'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd <= '0;
      dsr <= '0;
      rem <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      dvd <= dividend;
      dsr <= divisor;
      rem <= '0;
      cnt <= CW'(W);
      run <= 1'b1;
    end else if (run) begin
      dvd <= quotient;
      rem <= rem_n;
      cnt <= cnt - CW'(1);
      run <= (cnt != CW'(1));
    end
  end

endmodule

// File: rtl/hsv_object_tracker.sv
// Per-object HSV window classifier, mask output and frame centroid.
// Optional crosshair output under AIRPONG_CROSSHAIR_EN.
module hsv_object_tracker
  import airpong_pkg::*;
#(
  parameter int HCOUNT_W   = 11,
  parameter int VCOUNT_W   = 10,
  parameter int SUM_W      = 30,
  parameter int CNT_W      = 19,
  parameter int MIN_PIXELS = MIN_PIXELS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pixel_valid,
  input  logic                frame_end,
  input  logic [HCOUNT_W-1:0] hcount,
  input  logic [VCOUNT_W-1:0] vcount,
  input  logic [7:0]          h,
  input  logic [7:0]          s,
  input  logic [7:0]          v,
  input  logic [7:0]          h1_min,
  input  logic [7:0]          h1_max,
  input  logic [7:0]          h2_min,
  input  logic [7:0]          h2_max,
  input  logic [7:0]          s_min,
  input  logic [7:0]          s_max,
  input  logic [7:0]          v_min,
  input  logic [7:0]          v_max,
  output logic                mask,
  output logic                mask_valid,
  output logic [HCOUNT_W-1:0] x_center,
  output logic [VCOUNT_W-1:0] y_center,
  output logic                detected,
  output logic                centroid_valid,
  output logic                busy,
  output logic                overrun
`ifdef AIRPONG_CROSSHAIR_EN
  ,
  output logic                crosshair
`endif
);

  trk_state_e state, state_n;

  logic [SUM_W-1:0]    sum_x, sum_y;
  logic [CNT_W-1:0]    cnt;
  logic [SUM_W:0]      sx_add, sy_add;
  logic [CNT_W:0]      cn_add;
  logic [SUM_W-1:0]    sx_nxt, sy_nxt;
  logic [CNT_W-1:0]    cn_nxt;
  logic [SUM_W-1:0]    sy_snap;
  logic [CNT_W-1:0]    cn_snap;
  logic [HCOUNT_W-1:0] qx;
  logic [VCOUNT_W-1:0] qy;
  logic                det_n;

  logic                in_win;
  logic                fe_take;
  logic                go_div;
  logic                div_start;
  logic                div_done;
  logic [SUM_W-1:0]    div_dvd;
  logic [SUM_W-1:0]    div_dsr;
  logic [SUM_W-1:0]    div_q;
  logic                unused_q;

  assign in_win = pixel_valid
    && (((h >= h1_min) && (h <= h1_max))
     || ((h >= h2_min) && (h <= h2_max)))
    && (s >= s_min) && (s <= s_max)
    && (v >= v_min) && (v <= v_max);

  // Saturating accumulate; includes the pixel of this cycle so a
  // frame_end snapshot sees it.
  always_comb begin
    sx_add = {1'b0, sum_x} + (SUM_W+1)'(hcount);
    sy_add = {1'b0, sum_y} + (SUM_W+1)'(vcount);
    cn_add = {1'b0, cnt} + (CNT_W+1)'(1);
    sx_nxt = sum_x;
    sy_nxt = sum_y;
    cn_nxt = cnt;
    if (in_win) begin
      sx_nxt = sx_add[SUM_W] ? '1 : sx_add[SUM_W-1:0];
      sy_nxt = sy_add[SUM_W] ? '1 : sy_add[SUM_W-1:0];
      cn_nxt = cn_add[CNT_W] ? '1 : cn_add[CNT_W-1:0];
    end
  end

  assign fe_take = frame_end && (state == IDLE);
  assign go_div  = fe_take && (cn_nxt >= CNT_W'(MIN_PIXELS));

  // One divider serves both axes: y starts on the x done cycle.
  assign div_start = go_div || ((state == DIV_X) && div_done);
  assign div_dvd   = go_div ? sx_nxt : sy_snap;
  assign div_dsr   = go_div ? SUM_W'(cn_nxt) : SUM_W'(cn_snap);
  assign unused_q  = ^div_q[SUM_W-1:HCOUNT_W];

  seq_divider #(.W(SUM_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dvd),
    .divisor  (div_dsr),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fe_take) state_n = go_div ? DIV_X : DONE;
      DIV_X:   if (div_done) state_n = DIV_Y;
      DIV_Y:   if (div_done) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == DIV_X) || (state == DIV_Y);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask           <= 1'b0;
      mask_valid     <= 1'b0;
      sum_x          <= '0;
      sum_y          <= '0;
      cnt            <= '0;
      sy_snap        <= '0;
      cn_snap        <= '0;
      qx             <= '0;
      qy             <= '0;
      det_n          <= 1'b0;
      x_center       <= '0;
      y_center       <= '0;
      detected       <= 1'b0;
      centroid_valid <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      mask           <= in_win;
      mask_valid     <= pixel_valid;
      centroid_valid <= (state == DONE);
      if (frame_end) begin
        sum_x <= '0;
        sum_y <= '0;
        cnt   <= '0;
      end else begin
        sum_x <= sx_nxt;
        sum_y <= sy_nxt;
        cnt   <= cn_nxt;
      end
      if (frame_end && (state != IDLE)) overrun <= 1'b1;
      if (go_div) begin
        sy_snap <= sy_nxt;
        cn_snap <= cn_nxt;
      end
      if (fe_take) det_n <= go_div;
      if ((state == DIV_X) && div_done) qx <= div_q[HCOUNT_W-1:0];
      if ((state == DIV_Y) && div_done) qy <= div_q[VCOUNT_W-1:0];
      if (state == DONE) begin
        detected <= det_n;
        if (det_n) begin
          x_center <= qx;
          y_center <= qy;
        end
      end
    end
  end

`ifdef AIRPONG_CROSSHAIR_EN
  logic [HCOUNT_W-1:0] dx;
  logic [VCOUNT_W-1:0] dy;
  logic                xh;

  always_comb begin
    dx = (hcount >= x_center) ? hcount - x_center : x_center - hcount;
    dy = (vcount >= y_center) ? vcount - y_center : y_center - vcount;
    xh = pixel_valid && detected
      && (((dx == '0) && (dy <= VCOUNT_W'(8)))
       || ((dy == '0) && (dx <= HCOUNT_W'(8))));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) crosshair <= 1'b0;
    else        crosshair <= xh;
  end
`endif

endmodule
